// File: rtl/trigger_pulse_gen_pkg.sv
// Shared types and constants for the trigger pulse generator.
package trigger_pulse_gen_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DELAY   = 3'd1,
    S_PULSE   = 3'd2,
    S_HOLDOFF = 3'd3,
    S_GAP     = 3'd4
  } state_e;

  localparam int unsigned MISS_W_DEF = 8;
  localparam int unsigned MISS_SAT   = (1 << MISS_W_DEF) - 1;

  // State that follows the delay phase: a zero width skips the pulse entirely.
  function automatic state_e after_delay(input logic width_zero);
    return width_zero ? S_HOLDOFF : S_PULSE;
  endfunction

endpackage

// File: rtl/trigger_pulse_gen_counter.sv
// Loadable down-counter shared by every timed phase; flags the final cycle (count == 1).
module load_down_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         term_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_c = (cnt_q == W'(1));

endmodule

// File: rtl/trigger_pulse_gen.sv
// Trigger-to-pulse sequencer: delay, pulse (optionally a burst), holdoff.
// Burst mode is enabled by defining TRIGGER_PULSE_GEN_BURST_EN.
module trigger_pulse_gen
  import trigger_pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned HOLDOFF = 4,
  parameter int unsigned MISS_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              trig,
`ifdef TRIGGER_PULSE_GEN_BURST_EN
  input  logic [7:0]        burst_cnt,
`endif
  input  logic [CNT_W-1:0]  delay_cycles,
  input  logic [CNT_W-1:0]  width_cycles,
  output logic              pulse_out,
  output logic              busy,
  output logic              done,
  output logic [MISS_W-1:0] missed_count
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    width_q, width_d;
  logic [MISS_W-1:0]   missed_q, missed_d;
  logic                pulse_q, pulse_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cnt_load;
  logic [CNT_W-1:0]    cnt_val;
  logic                cnt_en;
  logic                cnt_term_c;
  logic                accept_c;
`ifdef TRIGGER_PULSE_GEN_BURST_EN
  logic [7:0]          pulses_left_q, pulses_left_d;
`endif

  assign accept_c = trig && arm && (state_q == S_IDLE);
  assign cnt_en   = (state_q != S_IDLE);

  load_down_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .term_c   (cnt_term_c)
  );

  // State and latched-config registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      width_q  <= '0;
      missed_q <= '0;
`ifdef TRIGGER_PULSE_GEN_BURST_EN
      pulses_left_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      missed_q <= missed_d;
`ifdef TRIGGER_PULSE_GEN_BURST_EN
      pulses_left_q <= pulses_left_d;
`endif
    end
  end

  // Next-state, counter reload and missed-trigger logic
  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    missed_d = missed_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
`ifdef TRIGGER_PULSE_GEN_BURST_EN
    pulses_left_d = pulses_left_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          width_d = width_cycles;
`ifdef TRIGGER_PULSE_GEN_BURST_EN
          pulses_left_d = (burst_cnt == 8'd0) ? 8'd1 : burst_cnt;
`endif
          if (delay_cycles != '0) begin
            state_d = S_DELAY;
          end else begin
            state_d = after_delay(width_cycles == '0);
          end
        end
      end
      S_DELAY: begin
        if (cnt_term_c) state_d = after_delay(width_q == '0);
      end
      S_PULSE: begin
        if (cnt_term_c) begin
`ifdef TRIGGER_PULSE_GEN_BURST_EN
          if (pulses_left_q > 8'd1) begin
            state_d       = S_GAP;
            pulses_left_d = pulses_left_q - 8'd1;
          end else begin
            state_d = S_HOLDOFF;
          end
`else
          state_d = S_HOLDOFF;
`endif
        end
      end
      S_GAP: begin
        if (cnt_term_c) state_d = S_PULSE;
      end
      S_HOLDOFF: begin
        if (cnt_term_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Every state change reloads the shared counter for the phase being entered
    cnt_load = (state_d != state_q);
    case (state_d)
      S_DELAY:        cnt_val = delay_cycles;
      S_PULSE, S_GAP: cnt_val = width_d;
      S_HOLDOFF:      cnt_val = CNT_W'(HOLDOFF);
      default:        cnt_val = '0;
    endcase

    if (trig && arm && (state_q != S_IDLE) && (missed_q != {MISS_W{1'b1}})) begin
      missed_d = missed_q + MISS_W'(1);
    end
  end

  // Output decode from the next state so the outputs register alongside it
  always_comb begin
    pulse_d = (state_d == S_PULSE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_HOLDOFF) && (state_q != S_HOLDOFF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pulse_out    = pulse_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign missed_count = missed_q;

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Self-checking bench for trigger_pulse_gen: table of sequences plus scoreboard of per-cycle outputs.
module tb_trigger_pulse_gen;
  import trigger_pulse_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        trig;
  logic [15:0] delay_cycles;
  logic [15:0] width_cycles;
  logic        pulse_out;
  logic        busy;
  logic        done;
  logic [7:0]  missed_count;
`ifdef TRIGGER_PULSE_GEN_BURST_EN
  logic [7:0]  burst_cnt;
`endif

  always #5 clk = ~clk;

  trigger_pulse_gen #(.CNT_W(16), .HOLDOFF(4), .MISS_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .trig         (trig),
`ifdef TRIGGER_PULSE_GEN_BURST_EN
    .burst_cnt    (burst_cnt),
`endif
    .delay_cycles (delay_cycles),
    .width_cycles (width_cycles),
    .pulse_out    (pulse_out),
    .busy         (busy),
    .done         (done),
    .missed_count (missed_count)
  );

  // Offsets are cycles after the acceptance cycle.
  typedef struct {
    int d;
    int w;
    int p_first;
    int p_len;
    int n_pulse;
    int done_at;
    int busy_last;
  } vec_t;

  typedef struct {
    logic pulse;
    logic busy;
    logic done;
  } exp_t;

  vec_t vecs[9];
  exp_t sb_q[$];
  int   checks     = 0;
  int   passed     = 0;
  int   exp_missed = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  task automatic push_seq(input vec_t v);
    exp_t e;
    int   period;
    int   rel;
    period = 2 * v.p_len;
    for (int k = 1; k <= v.busy_last; k++) begin
      rel     = k - v.p_first;
      e.pulse = (v.p_len > 0) && (rel >= 0) && ((rel % period) < v.p_len)
                && ((rel / period) < v.n_pulse);
      e.busy  = 1'b1;
      e.done  = (k == v.done_at);
      sb_q.push_back(e);
    end
  endtask

  // One clock: drive inputs, compare outputs against the scoreboard, account for the trigger.
  task automatic cycle(input logic t_v, input logic a_v, input int d, input int w, input int vec_idx);
    exp_t e;
    @(posedge clk);
    #1;
    trig         = t_v;
    arm          = a_v;
    delay_cycles = 16'(d);
    width_cycles = 16'(w);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = '{pulse: 1'b0, busy: 1'b0, done: 1'b0};
    @(negedge clk);
    check("pulse_out", int'(pulse_out), int'(e.pulse));
    check("busy", int'(busy), int'(e.busy));
    check("done", int'(done), int'(e.done));
    check("missed_count", int'(missed_count), exp_missed);
    if (t_v && a_v) begin
      if (e.busy) begin
        if (exp_missed < int'(MISS_SAT)) exp_missed++;
      end else if (vec_idx >= 0) begin
        push_seq(vecs[vec_idx]);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst  = 1'b1;
    trig = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    exp_missed = 0;
    @(negedge clk);
    check("rst_pulse_out", int'(pulse_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_missed_count", int'(missed_count), 0);
  endtask

  initial begin
    vecs[0] = '{d: 0,   w: 3,  p_first: 1,   p_len: 3,  n_pulse: 1, done_at: 4,   busy_last: 7};
    vecs[1] = '{d: 5,   w: 2,  p_first: 6,   p_len: 2,  n_pulse: 1, done_at: 8,   busy_last: 11};
    vecs[2] = '{d: 1,   w: 0,  p_first: 0,   p_len: 0,  n_pulse: 0, done_at: 2,   busy_last: 5};
    vecs[3] = '{d: 0,   w: 0,  p_first: 0,   p_len: 0,  n_pulse: 0, done_at: 1,   busy_last: 4};
    vecs[4] = '{d: 3,   w: 1,  p_first: 4,   p_len: 1,  n_pulse: 1, done_at: 5,   busy_last: 8};
    vecs[5] = '{d: 2,   w: 4,  p_first: 3,   p_len: 4,  n_pulse: 1, done_at: 7,   busy_last: 10};
    vecs[6] = '{d: 400, w: 1,  p_first: 401, p_len: 1,  n_pulse: 1, done_at: 402, busy_last: 405};
    vecs[7] = '{d: 0,   w: 10, p_first: 1,   p_len: 10, n_pulse: 1, done_at: 11,  busy_last: 14};
    vecs[8] = '{d: 0,   w: 2,  p_first: 1,   p_len: 2,  n_pulse: 3, done_at: 11,  busy_last: 14};

    rst          = 1'b1;
    arm          = 1'b0;
    trig         = 1'b0;
    delay_cycles = '0;
    width_cycles = '0;
`ifdef TRIGGER_PULSE_GEN_BURST_EN
    burst_cnt    = 8'd0;
`endif
    repeat (2) @(posedge clk);
    do_reset();
    repeat (3) cycle(1'b0, 1'b1, 0, 0, -1);

    // Table of single sequences; config and arm wander while busy
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, vecs[i].d, vecs[i].w, i);
      for (int k = 1; k <= vecs[i].busy_last + 2; k++) begin
        cycle(1'b0, 1'(k % 2), int'($urandom_range(0, 50)), int'($urandom_range(0, 50)), -1);
      end
    end

    // Misses during PULSE and on the last HOLDOFF cycle; arm=0 trigger while busy is ignored
    cycle(1'b1, 1'b1, 0, 3, 0);
    for (int k = 1; k <= 12; k++) begin
      cycle((k == 2) || (k == 4) || (k == 7), (k != 4), 0, 3, -1);
    end
    check("missed_after_two", int'(missed_count), 2);

    // Triggers with arm low in IDLE do nothing
    repeat (4) cycle(1'b1, 1'b0, 0, 3, -1);

    // Width change mid-DELAY must not affect the latched width
    cycle(1'b1, 1'b1, 5, 2, 1);
    for (int k = 1; k <= 13; k++) cycle(1'b0, 1'b1, 5, 9, -1);

    // Saturation of the missed counter during a long delay
    cycle(1'b1, 1'b1, 400, 1, 6);
    for (int k = 1; k <= 300; k++) cycle(1'b1, 1'b1, 0, 0, -1);
    check("missed_saturated", int'(missed_count), 255);
    for (int k = 301; k <= 408; k++) cycle(1'b0, 1'b1, 0, 0, -1);

    // Reset mid-PULSE aborts the sequence
    cycle(1'b1, 1'b1, 0, 10, 7);
    repeat (3) cycle(1'b0, 1'b1, 0, 10, -1);
    check("pulse_before_reset", int'(pulse_out), 1);
    do_reset();
    repeat (4) cycle(1'b0, 1'b1, 0, 0, -1);

`ifdef TRIGGER_PULSE_GEN_BURST_EN
    burst_cnt = 8'd3;
    cycle(1'b1, 1'b1, 0, 2, 8);
    burst_cnt = 8'd0;
    for (int k = 1; k <= 16; k++) cycle(1'b0, 1'b1, 0, 2, -1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/trigger_pulse_gen.md
Name: trigger_pulse_gen

Overview:
- Consumes single-cycle trigger strobes, such as the output of the edge-detect stage, and produces a timed output pulse.
- Sequence: a programmable delay, then a programmable-width high pulse, then a fixed holdoff.
- Used to turn a detected event into a precisely placed glitch or capture pulse in the FPGA trigger path.
- Also reports triggers that arrived while the block was busy and were dropped.

Parameters:
- CNT_W, 16, width of the delay and width counters and their config inputs.
- HOLDOFF, 4, cycles spent in HOLDOFF after each sequence; legal range is 1 or more.
- MISS_W, 8, width of the saturating missed-trigger counter.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  level; while high, a trigger in IDLE is accepted.
- trig  in  1  single-cycle trigger strobe.
- delay_cycles  in  CNT_W  cycles from acceptance to pulse start; sampled at acceptance.
- width_cycles  in  CNT_W  pulse high time in cycles; sampled at acceptance.
- pulse_out  out  1  registered output pulse.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle strobe marking sequence completion.
- missed_count  out  MISS_W  saturating count of dropped triggers.

Behaviour:
- Reset: state=IDLE; pulse_out=0, busy=0, done=0, missed_count=0; all latched config cleared. A reset mid-sequence aborts it; pulse_out is 0 from the cycle after rst is sampled high.
- States: IDLE, DELAY, PULSE, HOLDOFF (plus GAP when the burst option is compiled in).
- Acceptance: trig=1 AND arm=1 AND state==IDLE in cycle t. delay_cycles and width_cycles are latched at the t edge.
- Transitions from acceptance:
  - D>0: DELAY for cycles t+1..t+D.
  - D=0: DELAY is skipped.
  - W>0: PULSE for W cycles immediately after delay.
  - W=0: PULSE is skipped; pulse_out never rises, but the sequence still completes normally.
  - HOLDOFF: exactly HOLDOFF cycles, then IDLE.
- Outputs:
  - pulse_out = (state==PULSE), driven from a register with no combinational path from trig. For D=0, W=3: pulse_out is high in cycles t+1, t+2, t+3.
  - done = 1 in the first HOLDOFF cycle only.
  - busy = 1 from t+1 until the last HOLDOFF cycle, inclusive.
- Dropped triggers: trig=1 with arm=1 and state!=IDLE increments missed_count. It saturates at 2^MISS_W-1; there is no wrap.
- trig with arm=0 is ignored and not counted.
- arm falling mid-sequence does not abort the sequence; only rst aborts.
- trig in the same cycle the FSM returns to IDLE (last HOLDOFF cycle) counts as missed. A trigger is accepted only when the current state is IDLE.
- Counters are down-counters of CNT_W bits, loaded at state entry and leaving at 1. Maximum delay and width are 2^CNT_W-1.
- Config inputs may change freely while busy; the latched copies are used.

Optional Feature:
- Macro: TRIGGER_PULSE_GEN_BURST_EN.
- When defined:
  - Adds input burst_cnt (8 bits), latched at acceptance; 0 is treated as 1.
  - After each PULSE, if pulses remain, the FSM enters GAP (pulse_out=0) for W cycles, then PULSE again.
  - HOLDOFF and done follow the final pulse only.
  - W=0 with a burst: all PULSE and GAP states are skipped.
- When undefined: burst_cnt and GAP do not exist; exactly one pulse per trigger.

Decomposition:
- Package trigger_pulse_gen_pkg holds:
  - the state enum typedef (IDLE, DELAY, PULSE, HOLDOFF, GAP), where GAP is present always and unused without the macro;
  - a localparam for the missed-counter saturation value.
- One natural sub-module, load_down_counter. Inputs: load, load value, enable. Output: a terminal flag asserted when the count is 1. It is instantiated once and shared by DELAY, PULSE, GAP and HOLDOFF.

Test Plan:
- Basic sequence: rst, arm=1, D=0, W=3, trig at cycle 10 -> pulse_out high cycles 11-13; done at 14; busy high 11-17; IDLE at 18.
- Delayed pulse: D=5, W=2, trig at 10 -> pulse_out high 16-17 only; done at 18.
- Missed triggers: trig during PULSE and on the last HOLDOFF cycle -> missed_count=2, no second pulse. Hold trig high for 300 cycles while busy -> missed_count saturates at 255.
- Arm and config sampling: trig with arm=0 -> nothing happens, missed_count unchanged. Change width_cycles mid-DELAY from 2 to 9 -> pulse stays 2 cycles.
- Zero width and reset: W=0, D=1 -> pulse_out never high, done at t+2. Assert rst mid-PULSE with W=10 -> pulse_out 0 the following cycle, busy=0, all outputs at reset values.
- Burst (TRIGGER_PULSE_GEN_BURST_EN defined): burst_cnt=3, D=0, W=2, trig at 10 -> pulse_out high 11-12, 15-16, 19-20; done at 21.
